exe_add_dispatch: RTL and testbench
===================================

// Module: exe_add_dispatch
// PURPOSE
//  Upstream feeder for the EXE add/sub unit. Buffers decoded add/sub ops from the
//  issue stage in a small FIFO and launches them one at a time to the adder as a
//  start pulse with stable operands. Waits for the adder's valid, captures the
//  result with its tag, and holds it on a valid/ready port for writeback.
//  Exactly one op is in flight in the adder at any time.
// PARAMETERS
//  DEPTH          4   FIFO entries (power of 2, >=2)
//  TAG_W          4   destination tag width, carried alongside each op
//  CAPTURE_DELAY  1   cycles after add_valid high at which add_result is sampled (0..3)
//  ISSUE_GAP      2   min cycles with add_start low between capture and next add_start
// PORTS
//  clk         in   1      clock, rising edge
//  rst_n       in   1      asynchronous active-low reset
//  in_valid    in   1      upstream op valid
//  in_ready    out  1      FIFO can accept (registered, = !full)
//  in_op       in   3      0=add (a+b), 1=sub (b-a), 2..7 illegal
//  in_a        in   32     operand a
//  in_b        in   32     operand b
//  in_tag      in   TAG_W  destination tag
//  add_start   out  1      one-cycle launch pulse to adder
//  add_op      out  3      op to adder, stable from add_start until capture
//  add_a       out  32     operand a to adder, stable likewise
//  add_b       out  32     operand b to adder, stable likewise
//  add_valid   in   1      adder completion strobe
//  add_result  in   32     adder result
//  out_valid   out  1      result register holds an unconsumed result
//  out_ready   in   1      downstream accepts result
//  out_result  out  32     captured result
//  out_tag     out  TAG_W  tag of captured result
//  out_err     out  1      1 = illegal op, out_result forced to 0
//  fifo_count  out  $clog2(DEPTH)+1  occupied FIFO entries
// BEHAVIOUR
//  Reset (async assert, sync deassert use): FSM=IDLE, FIFO empty, in_ready=1,
//   add_start=0, add_op/a/b=0, out_valid=0, out_result=0, out_tag=0, out_err=0,
//   fifo_count=0. Reset mid-op drops in-flight op and all queued ops.
//  FIFO: push when in_valid&in_ready; pop on leaving IDLE. in_ready registered from
//   next-cycle count, so push+pop in same cycle when full: no push. Pointers wrap mod DEPTH.
//  FSM states:
//   IDLE : FIFO non-empty & out_valid=0 & gap done -> pop head into add_op/a/b/tag reg;
//          legal op -> ISSUE; illegal op -> ERR. Else stay.
//   ISSUE: add_start=1 for exactly this cycle -> WAIT.
//   WAIT : add_valid=1 -> CAPT (CAPTURE_DELAY>0) or capture now (=0) -> DONE.
//          add_valid seen while not in WAIT is ignored.
//   CAPT : count CAPTURE_DELAY cycles after add_valid; on final count register
//          out_result=add_result, out_tag, out_err=0 -> DONE.
//   ERR  : out_result=0, out_err=1, out_tag=tag (1 cycle, adder not touched) -> DONE.
//   DONE : out_valid=1; on out_ready -> IDLE, out_valid=0 next cycle.
//  Gap counter: loads ISSUE_GAP on capture/ERR, decrements each cycle to 0; IDLE
//   only launches when 0. Gap overlaps DONE.
//  Latency, legal op, empty FIFO, out_ready=1: in push @T -> add_start @T+2 ->
//   add_valid @T+3 -> out_valid @T+4+CAPTURE_DELAY.
//  Arithmetic is in the adder; this block passes 32-bit values unmodified.
//  out_result/out_tag/out_err stable while out_valid=1 & out_ready=0.
// TESTING
//  1 reset mid-WAIT: rst_n low 1 cycle -> all outputs 0, in_ready=1, fifo_count=0.
//  2 single add a=5,b=7,tag=3 -> one add_start pulse, out_result=12, out_tag=3, out_err=0.
//  3 sub a=1,b=0 -> out_result=32'hFFFF_FFFF; add a=32'hFFFF_FFFF,b=1 -> 0 (wrap).
//  4 push 5 ops back-to-back with out_ready=0, DEPTH=4 -> in_ready low after 4
//    (1 popped -> in flight); results in push order; add_start spacing >= ISSUE_GAP.
//  5 op=5, tag=9 -> no add_start, out_err=1, out_result=0, out_tag=9.
//  6 out_ready low 10 cycles -> out_* held stable, no new add_start until accepted.

Source files
------------

// File: rtl/exe_add_dispatch.sv
// Dispatch stage for the EXE add/sub unit: queues decoded ops in a small FIFO, launches
// them to the adder one at a time and holds each tagged result on a valid/ready port.
module exe_add_dispatch #(
  parameter int DEPTH         = 4,
  parameter int TAG_W         = 4,
  parameter int CAPTURE_DELAY = 1,
  parameter int ISSUE_GAP     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_op,
  input  logic [31:0]            in_a,
  input  logic [31:0]            in_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   add_start,
  output logic [2:0]             add_op,
  output logic [31:0]            add_a,
  output logic [31:0]            add_b,
  input  logic                   add_valid,
  input  logic [31:0]            add_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_result,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_err,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int GAP_W = $clog2(ISSUE_GAP + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_CAPT, S_ERR, S_DONE
  } state_e;

  typedef struct packed {
    logic [2:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
  } entry_t;

  state_e           state_q, state_d;
  entry_t           mem_q [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready_q;
  logic             push, pop, capture, cap_done;
  logic [1:0]       cap_cnt_q;
  logic [GAP_W-1:0] gap_q;
  logic [2:0]       op_q;
  logic [31:0]      a_q, b_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      result_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             err_q;

  assign head     = mem_q[rd_ptr_q];
  assign push     = in_valid && in_ready_q;
  assign pop      = (state_q == S_IDLE) && (count_q != '0) && (gap_q == '0);
  assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  assign cap_done = (cap_cnt_q == 2'(CAPTURE_DELAY));
  assign capture  = ((state_q == S_WAIT) && add_valid && (CAPTURE_DELAY == 0)) ||
                    ((state_q == S_CAPT) && cap_done);

  // NOTE: the op storage has no reset; count_q and the pointers define which entries
  // are live, so stale contents are never observed and the array stays a plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{op: in_op, a: in_a, b: in_b, tag: in_tag};
  end

  // NOTE: every clocked process uses non-blocking assignments so all registers update
  // from the same pre-edge values regardless of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_d;
      in_ready_q <= (count_d != CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d is defaulted before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pop) state_d = (head.op <= 3'd1) ? S_ISSUE : S_ERR;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (add_valid) state_d = (CAPTURE_DELAY == 0) ? S_DONE : S_CAPT;
      S_CAPT:  if (cap_done) state_d = S_DONE;
      S_ERR:   state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    add_start = (state_q == S_ISSUE);
    out_valid = (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      tag_q     <= '0;
      cap_cnt_q <= '0;
      gap_q     <= '0;
      result_q  <= '0;
      out_tag_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (pop) begin
        op_q  <= head.op;
        a_q   <= head.a;
        b_q   <= head.b;
        tag_q <= head.tag;
      end
      // cap_cnt_q counts cycles since add_valid; the result is sampled when it hits the delay
      if ((state_q == S_WAIT) && add_valid)      cap_cnt_q <= 2'd1;
      else if ((state_q == S_CAPT) && !cap_done) cap_cnt_q <= cap_cnt_q + 2'd1;
      if (capture) begin
        result_q  <= add_result;
        out_tag_q <= tag_q;
        err_q     <= 1'b0;
      end else if (state_q == S_ERR) begin
        result_q  <= '0;
        out_tag_q <= tag_q;
        err_q     <= 1'b1;
      end
      if (capture || (state_q == S_ERR)) gap_q <= GAP_W'(ISSUE_GAP);
      else if (gap_q != '0)              gap_q <= gap_q - GAP_W'(1);
    end
  end

  assign in_ready   = in_ready_q;
  assign fifo_count = count_q;
  assign add_op     = op_q;
  assign add_a      = a_q;
  assign add_b      = b_q;
  assign out_result = result_q;
  assign out_tag    = out_tag_q;
  assign out_err    = err_q;
endmodule

// File: tb/tb_exe_add_dispatch.sv
// Directed bench for exe_add_dispatch: table of single ops with hand-computed results,
// plus reset-mid-op and backpressure sequences against a behavioural adder.
module tb_exe_add_dispatch;
  localparam int DEPTH         = 4;
  localparam int TAG_W         = 4;
  localparam int CAPTURE_DELAY = 1;
  localparam int ISSUE_GAP     = 2;
  localparam logic [31:0] GARB = 32'hDEAD_BEEF;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid, in_ready;
  logic [2:0]             in_op;
  logic [31:0]            in_a, in_b;
  logic [TAG_W-1:0]       in_tag;
  logic                   add_start;
  logic [2:0]             add_op;
  logic [31:0]            add_a, add_b;
  logic                   add_valid;
  logic [31:0]            add_result;
  logic                   out_valid, out_ready;
  logic [31:0]            out_result;
  logic [TAG_W-1:0]       out_tag;
  logic                   out_err;
  logic [$clog2(DEPTH):0] fifo_count;

  exe_add_dispatch #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .CAPTURE_DELAY(CAPTURE_DELAY), .ISSUE_GAP(ISSUE_GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .in_tag(in_tag),
    .add_start(add_start), .add_op(add_op), .add_a(add_a), .add_b(add_b),
    .add_valid(add_valid), .add_result(add_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_err(out_err), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp_result;
    logic             exp_err;
  } vec_t;

  typedef struct {
    logic [31:0]      result;
    logic [TAG_W-1:0] tag;
    logic             err;
    int               cyc;
  } res_t;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   adder_lat = 0;
  int   start_q[$];
  res_t res_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitors sample on the falling edge, away from the DUT's active edge.
  always @(negedge clk) if (add_start) start_q.push_back(cyc);
  always @(negedge clk) if (out_valid && out_ready) res_q.push_back('{out_result, out_tag, out_err, cyc});

  // Adder model: valid one cycle after start (plus adder_lat), result valid only in the
  // cycle CAPTURE_DELAY=1 after valid, garbage elsewhere.
  initial begin
    logic [2:0]  op_s;
    logic [31:0] a_s, b_s, res;
    add_valid  = 1'b0;
    add_result = GARB;
    forever begin
      @(negedge clk);
      if (add_start) begin
        op_s = add_op;
        a_s  = add_a;
        b_s  = add_b;
        res  = (op_s == 3'd1) ? (b_s - a_s) : (a_s + b_s);
        repeat (adder_lat) @(negedge clk);
        @(negedge clk); add_valid = 1'b1; add_result = GARB;
        @(negedge clk); add_valid = 1'b0; add_result = res;
        @(negedge clk); add_result = GARB;
        if (adder_lat == 0) check("operands_stable", {add_op, add_a, add_b}, {op_s, a_s, b_s});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag, output int t_push);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    for (int n = 0; n < 50 && !acc; n++) begin
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    t_push = cyc;
    check("push_accepted", acc, 1);
  endtask

  task automatic wait_result(output res_t r, output bit ok);
    ok = 1'b0;
    r  = '{32'h0, '0, 1'b0, 0};
    for (int n = 0; n < 100 && !ok; n++) begin
      if (res_q.size() != 0) begin
        r  = res_q.pop_front();
        ok = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    check("result_arrives", ok, 1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_outs_zero"}, |{add_start, add_op, add_a, add_b, out_valid, out_result,
                                  out_tag, out_err}, 0);
    check({name, "_in_ready"}, in_ready, 1);
    check({name, "_fifo_count"}, fifo_count, 0);
  endtask

  vec_t tbl[8];
  vec_t bp[5];

  initial begin
    int   tp, s0, r0, n0;
    int   min_sp;
    res_t r;
    bit   ok, stable;
    logic [37:0] snap;

    tbl[0] = '{3'd0, 32'd5,          32'd7,          4'd3, 32'd12,         1'b0};
    tbl[1] = '{3'd1, 32'd1,          32'd0,          4'd1, 32'hFFFF_FFFF,  1'b0};
    tbl[2] = '{3'd0, 32'hFFFF_FFFF,  32'd1,          4'd2, 32'h0,          1'b0};
    tbl[3] = '{3'd1, 32'd3,          32'd10,         4'd4, 32'd7,          1'b0};
    tbl[4] = '{3'd5, 32'd1234,       32'd5678,       4'd9, 32'h0,          1'b1};
    tbl[5] = '{3'd0, 32'h1234_5678,  32'h1111_1111,  4'd6, 32'h2345_6789,  1'b0};
    tbl[6] = '{3'd7, 32'd1,          32'd1,          4'hF, 32'h0,          1'b1};
    tbl[7] = '{3'd1, 32'h8000_0000,  32'h0,          4'd7, 32'h8000_0000,  1'b0};

    bp[0] = '{3'd0, 32'd1,          32'd2,   4'hA, 32'd3,   1'b0};
    bp[1] = '{3'd1, 32'd2,          32'd9,   4'hB, 32'd7,   1'b0};
    bp[2] = '{3'd0, 32'd100,        32'd200, 4'hC, 32'd300, 1'b0};
    bp[3] = '{3'd6, 32'd5,          32'd5,   4'hD, 32'h0,   1'b1};
    bp[4] = '{3'd0, 32'hFFFF_FFFE,  32'd3,   4'hE, 32'd1,   1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(2);

    // Single ops: tp is the cycle after the push edge, so add_start lands at tp+1 and
    // a legal result at tp+3+CAPTURE_DELAY; an illegal op reaches DONE at tp+2.
    foreach (tbl[i]) begin
      s0 = start_q.size();
      push_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].tag, tp);
      wait_result(r, ok);
      if (ok) begin
        check($sformatf("vec%0d_result", i), r.result, tbl[i].exp_result);
        check($sformatf("vec%0d_tag", i), r.tag, tbl[i].tag);
        check($sformatf("vec%0d_err", i), r.err, tbl[i].exp_err);
        check($sformatf("vec%0d_latency", i), r.cyc - tp,
              tbl[i].exp_err ? 2 : 3 + CAPTURE_DELAY);
      end
      check($sformatf("vec%0d_starts", i), start_q.size() - s0, tbl[i].exp_err ? 0 : 1);
      if (!tbl[i].exp_err && start_q.size() > s0)
        check($sformatf("vec%0d_start_cycle", i), start_q[s0] - tp, 1);
      idle(4);
    end

    // Reset while the adder is busy: queued and in-flight ops vanish, late add_valid ignored.
    adder_lat = 6;
    s0 = start_q.size();
    push_op(3'd0, 32'd11, 32'd22, 4'd1, tp);
    push_op(3'd0, 32'd33, 32'd44, 4'd2, tp);
    for (int n = 0; n < 20 && start_q.size() == s0; n++) idle(1);
    check("rstw_started", start_q.size() - s0, 1);
    idle(2);
    check("rstw_queued", fifo_count, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("rstw");
    rst_n = 1'b1;
    n0 = start_q.size();
    r0 = res_q.size();
    idle(12);
    adder_lat = 0;
    check("rstw_no_start", start_q.size() - n0, 0);
    check("rstw_no_result", res_q.size() - r0, 0);
    check("rstw_out_valid", out_valid, 0);
    check("rstw_fifo_count", fifo_count, 0);

    // Backpressure: five pushes with out_ready low, then a held result, then drain.
    out_ready = 1'b0;
    s0 = start_q.size();
    r0 = res_q.size();
    foreach (bp[i]) push_op(bp[i].op, bp[i].a, bp[i].b, bp[i].tag, tp);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_fifo_count", fifo_count, 4);
    for (int n = 0; n < 50 && !out_valid; n++) idle(1);
    check("bp_out_valid", out_valid, 1);
    snap = {out_valid, out_result, out_tag, out_err};
    stable = 1'b1;
    repeat (10) begin
      idle(1);
      if ({out_valid, out_result, out_tag, out_err} !== snap) stable = 1'b0;
    end
    check("hold_stable", stable, 1);
    check("hold_result", snap[37:0], {1'b1, bp[0].exp_result, bp[0].tag, bp[0].exp_err});
    check("hold_one_start", start_q.size() - s0, 1);
    check("hold_no_accept", res_q.size() - r0, 0);
    out_ready = 1'b1;
    foreach (bp[i]) begin
      wait_result(r, ok);
      if (ok) begin
        check($sformatf("bp%0d_result", i), r.result, bp[i].exp_result);
        check($sformatf("bp%0d_tag", i), r.tag, bp[i].tag);
        check($sformatf("bp%0d_err", i), r.err, bp[i].exp_err);
      end
    end
    check("bp_starts", start_q.size() - s0, 4);
    min_sp = 1000;
    for (int k = s0 + 1; k < start_q.size(); k++)
      if (start_q[k] - start_q[k-1] < min_sp) min_sp = start_q[k] - start_q[k-1];
    check("bp_min_spacing_ok", (min_sp >= ISSUE_GAP + 1), 1);
    // Back-to-back legal ops with out_ready high: ISSUE,WAIT,CAPT,DONE, then IDLE x2 for the gap.
    if (start_q.size() >= s0 + 3)
      check("bp_exact_spacing", start_q[s0+2] - start_q[s0+1], 6);
    idle(4);
    check("bp_drained_count", fifo_count, 0);
    check("bp_drained_ready", in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
